// File: rtl/adc_pair_sampler.sv
// adc_pair_sampler
// Runs the dual-output simultaneous-sampling SPI ADC and hands paired
// voltage/current samples, converted to the 12-bit ADC format, to the
// igniter resistance path as one-cycle strobes.
//
// A frame is 16 SCLK bits shifted in MSB first on both data lines together.
// The period counter starts at 0 on the edge where chip select drops, so a
// new frame starts exactly every SAMPLE_PERIOD clocks while enabled. All pin
// outputs and sample outputs are registered.

module adc_pair_sampler #(
  parameter int SCLK_DIV      = 2,
  parameter int SAMPLE_PERIOD = 96
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  input  logic        adc_sdata_v,
  input  logic        adc_sdata_i,
  output logic        valid_out,
  output logic [11:0] v_out,
  output logic [11:0] i_out,
  output logic        frame_err
);

  // The divider counter still needs one bit when SCLK_DIV is 1.
  localparam int DIV_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int PCNT_W = $clog2(SAMPLE_PERIOD);

  localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(SCLK_DIV - 1);
  localparam logic [PCNT_W-1:0] PERIOD_LAST = PCNT_W'(SAMPLE_PERIOD - 1);
  localparam logic [4:0]        BITS_DONE   = 5'd16;
  localparam logic [11:0]       OUT_RESET   = 12'h7FF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic              enable_q;

  logic [PCNT_W-1:0] period_cnt;
  logic [PCNT_W-1:0] period_nxt;
  logic [DIV_W-1:0]  div_cnt;
  logic [DIV_W-1:0]  div_nxt;
  logic [4:0]        bit_cnt;
  logic [4:0]        bit_nxt;

  logic [15:0]       shift_v;
  logic [15:0]       shift_v_nxt;
  logic [15:0]       shift_i;
  logic [15:0]       shift_i_nxt;

  logic              cs_n_nxt;
  logic              sclk_nxt;
  logic              valid_nxt;
  logic [11:0]       v_nxt;
  logic [11:0]       i_nxt;
  logic              err_nxt;

  // Raw two's-complement sample to ADC format: keep the sign bit, invert the
  // magnitude bits, so raw 0 lands on mid-scale 12'h7FF.
  function automatic logic [11:0] to_adc_format(input logic [11:0] raw);
    return {raw[11], raw[10:0] ^ 11'h7FF};
  endfunction

  // Register the enable request; it is only looked at in IDLE and at GAP end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_q <= 1'b0;
    end else begin
      enable_q <= enable;
    end
  end

  // Next-state, counter, shift and output logic for the frame sequencer.
  always_comb begin
    state_nxt   = state;
    period_nxt  = period_cnt;
    div_nxt     = div_cnt;
    bit_nxt     = bit_cnt;
    shift_v_nxt = shift_v;
    shift_i_nxt = shift_i;
    cs_n_nxt    = adc_cs_n;
    sclk_nxt    = adc_sclk;
    valid_nxt   = 1'b0;
    v_nxt       = v_out;
    i_nxt       = i_out;
    err_nxt     = frame_err;

    case (state)
      IDLE: begin
        period_nxt = '0;
        div_nxt    = '0;
        bit_nxt    = '0;
        cs_n_nxt   = 1'b1;
        sclk_nxt   = 1'b1;
        if (enable_q) begin
          state_nxt = FRAME;
          cs_n_nxt  = 1'b0;
        end
      end

      FRAME: begin
        period_nxt = (period_cnt == PERIOD_LAST) ? '0 : period_cnt + PCNT_W'(1);
        if (bit_cnt == BITS_DONE) begin
          // All 16 bits are in: release the ADC and publish the pair.
          state_nxt = GAP;
          cs_n_nxt  = 1'b1;
          sclk_nxt  = 1'b1;
          div_nxt   = '0;
          bit_nxt   = '0;
          valid_nxt = 1'b1;
          v_nxt     = to_adc_format(shift_v[11:0]);
          i_nxt     = to_adc_format(shift_i[11:0]);
          err_nxt   = (|shift_v[15:12]) | (|shift_i[15:12]);
        end else if (div_cnt == DIV_LAST) begin
          div_nxt  = '0;
          sclk_nxt = ~adc_sclk;
          if (!adc_sclk) begin
            // SCLK is about to rise: sample both lines on this same edge.
            shift_v_nxt = {shift_v[14:0], adc_sdata_v};
            shift_i_nxt = {shift_i[14:0], adc_sdata_i};
            bit_nxt     = bit_cnt + 5'd1;
          end
        end else begin
          div_nxt = div_cnt + DIV_W'(1);
        end
      end

      GAP: begin
        cs_n_nxt = 1'b1;
        sclk_nxt = 1'b1;
        div_nxt  = '0;
        bit_nxt  = '0;
        if (period_cnt == PERIOD_LAST) begin
          period_nxt = '0;
          if (enable_q) begin
            state_nxt = FRAME;
            cs_n_nxt  = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          period_nxt = period_cnt + PCNT_W'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
        cs_n_nxt  = 1'b1;
        sclk_nxt  = 1'b1;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Counters, shift registers and registered pin/sample outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_cnt <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      shift_v    <= '0;
      shift_i    <= '0;
      adc_cs_n   <= 1'b1;
      adc_sclk   <= 1'b1;
      valid_out  <= 1'b0;
      v_out      <= OUT_RESET;
      i_out      <= OUT_RESET;
      frame_err  <= 1'b0;
    end else begin
      period_cnt <= period_nxt;
      div_cnt    <= div_nxt;
      bit_cnt    <= bit_nxt;
      shift_v    <= shift_v_nxt;
      shift_i    <= shift_i_nxt;
      adc_cs_n   <= cs_n_nxt;
      adc_sclk   <= sclk_nxt;
      valid_out  <= valid_nxt;
      v_out      <= v_nxt;
      i_out      <= i_nxt;
      frame_err  <= err_nxt;
    end
  end

endmodule

// File: doc/adc_pair_sampler.md
# adc_pair_sampler

Drives the launch controller's dual-output simultaneous-sampling SPI ADC and returns paired voltage/current samples in the 12-bit ADC format consumed by the igniter resistance path. One frame captures both channels, and a new frame starts every SAMPLE_PERIOD clocks while enabled. Each completed frame produces a single-cycle `valid_out` strobe carrying `v_out`/`i_out`. The block sits between the ADC pins and the resistance calculation logic, and is the producer side of that sample interface.

## Interface
- SCLK_DIV, 2, clk cycles per SCLK half-period; legal range ≥1.
- SAMPLE_PERIOD, 96, clk cycles between frame starts; must be ≥ 32*SCLK_DIV+4.
- clk  in  1  system clock (48 MHz).
- reset  in  1  asynchronous, active-high.
- enable  in  1  run sampling while high.
- adc_cs_n  out  1  ADC chip select, active low, registered.
- adc_sclk  out  1  ADC serial clock, idles high, registered.
- adc_sdata_v  in  1  ADC voltage-channel serial data.
- adc_sdata_i  in  1  ADC current-channel serial data.
- valid_out  out  1  one-cycle strobe; `v_out`, `i_out` and `frame_err` are valid in that cycle.
- v_out  out  12  voltage sample in ADC format; held between strobes.
- i_out  out  12  current sample in ADC format; held between strobes.
- frame_err  out  1  high with `valid_out` when a frame's leading bits are nonzero.

## Operation
- **Frame:** 16 SCLK bits, MSB first, on both data lines simultaneously.
  - Bits 15:12 are leading zeros.
  - Bits 11:0 are the raw two's-complement sample.
- **ADC format:** `{raw[11], raw[10:0] ^ 11'h7FF}`. Raw 0 maps to 12'h7FF.
- **States:** IDLE, FRAME, GAP.
  - IDLE: `adc_cs_n`=1, `adc_sclk`=1, period counter held at 0. When `enable`=1, the next edge enters FRAME.
  - FRAME: `adc_cs_n`=0, SCLK toggles, bit counter runs 0..15. After bit 15 is captured, go to GAP.
  - GAP: `adc_cs_n`=1, `adc_sclk`=1. When the period counter reaches SAMPLE_PERIOD-1:
    - go to FRAME if `enable`=1;
    - otherwise go to IDLE.
- **Enable:** sampled only in IDLE and at the GAP end. Deasserting `enable` mid-frame does not abort the frame; that frame completes and strobes.
- **Capture:** `adc_sdata_v` and `adc_sdata_i` are shifted in on the same clk edge where `adc_sclk` goes 0→1. Data are not resynchronised.
- **Shift registers:** two 16-bit registers. The output stage converts bits 11:0 to ADC format.
- **frame_err:** set when bits 15:12 of either line are nonzero. Data are still output unchanged.
- **Reset values (asynchronous):**
  - `adc_cs_n`=1, `adc_sclk`=1, `valid_out`=0, `frame_err`=0;
  - `v_out`=12'h7FF, `i_out`=12'h7FF;
  - state IDLE, all counters 0.
- **Reset mid-frame:** the frame is abandoned, with no strobe. Sampling restarts from IDLE after reset release if `enable`=1.

## Timing
- **T0** is the edge where `adc_cs_n` goes low.
- **SCLK edges:** for bit k=0..15:
  - `adc_sclk` falls at T0+SCLK_DIV*(2k+1);
  - `adc_sclk` rises at T0+SCLK_DIV*(2k+2), where bit k is captured.
- **Last capture:** T0+32*SCLK_DIV; this is T0+64 at the default SCLK_DIV.
- **End of frame:** at T0+32*SCLK_DIV+1, `adc_cs_n` goes high and `valid_out`=1 for exactly one cycle with new data.
- **Next frame:** T0+SAMPLE_PERIOD, if enabled. The minimum CS-high time is 3 cycles at the minimum legal SAMPLE_PERIOD.
- **Enable latency:** `enable` rising while in IDLE gives T0 one cycle after `enable` is registered high.
- **Counter wrap:** the period counter wraps at SAMPLE_PERIOD-1. There is no drift: frames repeat at an exact SAMPLE_PERIOD while `enable` stays high.
- **Output hold:** `valid_out` never asserts in consecutive cycles. `v_out`/`i_out` hold their values indefinitely between strobes and in IDLE.

## Test plan
- Default params, `enable`=1, ADC model returns v raw 12'h123 and i raw 12'h045 with zero leading bits:
  - `valid_out` at T0+65;
  - `v_out`=12'h6DC, `i_out`=12'h7BA, `frame_err`=0.
- Negative and full-scale samples: v raw 12'hF00 and i raw 12'h7FF give `v_out`=12'h8FF and `i_out`=12'h000.
- Leading bits 4'b0001 on `adc_sdata_i` only: `frame_err`=1 in the strobe cycle, with data still converted.
- `enable` held high across 3 frames: `adc_cs_n` falls every 96 cycles and exactly 3 one-cycle strobes occur; check the SCLK edge count (16 rising edges per frame) and the CS-high gap of 31 cycles.
- `enable` dropped at T0+20:
  - the frame completes and strobes at T0+65;
  - no further `adc_cs_n` fall occurs;
  - outputs hold their values.
- `reset` asserted asynchronously at T0+30:
  - outputs go immediately to the reset values, with no strobe;
  - after release with `enable`=1, a fresh frame starts and strobes correct data.
